// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-end sequencer.
package calc_pkg;

  localparam int OPND_W = 4;
  localparam int RES_W  = 8;
  localparam int OP_W   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_MUL = 3'b101;

endpackage

// File: rtl/calc_sequencer_settle_counter.sv
// Loadable down-counter that stops at zero and flags it.
module settle_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (dec_i && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Collects A, B and opcode over three ENTER presses, drives the calculator,
// then captures its result after a settle interval.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_OPS       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPND_W-1:0] sw_val_i,
  input  logic [OP_W-1:0]   sw_op_i,
  input  logic              btn_enter_i,
  input  logic              btn_clear_i,
  input  logic              chain_i,
  output logic [OPND_W-1:0] calc_a_o,
  output logic [OPND_W-1:0] calc_b_o,
  output logic [OP_W-1:0]   calc_op_o,
  input  logic [RES_W-1:0]  calc_result_i,
  output logic [RES_W-1:0]  result_o,
  output logic              result_valid_o,
  output logic              busy_o,
  output logic              op_err_o,
  output logic [2:0]        state_dbg_o
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [OP_W:0] NUM_OPS_W = (OP_W + 1)'(NUM_OPS);

  state_e            state_q;
  logic [OPND_W-1:0] calc_a_q, calc_b_q;
  logic [OP_W-1:0]   calc_op_q;
  logic [RES_W-1:0]  result_q;
  logic              result_valid_q, busy_q, op_err_q, clr_pend_q;

  logic op_legal, clear_now, cnt_load, cnt_dec, cnt_zero;

  assign op_legal  = ({1'b0, sw_op_i} < NUM_OPS_W);
  assign clear_now = btn_clear_i || clr_pend_q;
  assign cnt_load  = (state_q == GET_OP) && btn_enter_i && !clear_now && op_legal;
  assign cnt_dec   = (state_q == EXEC);

  settle_counter #(.W(CNT_W)) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (CNT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      calc_a_q       <= '0;
      calc_b_q       <= '0;
      calc_op_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      op_err_q       <= 1'b0;
      clr_pend_q     <= 1'b0;
    end else if (state_q == EXEC) begin
      // A clear arriving mid-execution waits until the capture has landed.
      if (btn_clear_i) clr_pend_q <= 1'b1;
      if (cnt_zero) begin
        result_q       <= calc_result_i;
        result_valid_q <= 1'b1;
        busy_q         <= 1'b0;
        state_q        <= DONE;
      end
    end else if (clear_now) begin
      state_q        <= IDLE;
      result_valid_q <= 1'b0;
      op_err_q       <= 1'b0;
      clr_pend_q     <= 1'b0;
    end else if (btn_enter_i) begin
      case (state_q)
        IDLE: begin
          calc_a_q       <= sw_val_i;
          result_valid_q <= 1'b0;
          state_q        <= GET_B;
        end
        GET_B: begin
          calc_b_q <= sw_val_i;
          state_q  <= GET_OP;
        end
        GET_OP: begin
          if (op_legal) begin
            calc_op_q <= sw_op_i;
            op_err_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= EXEC;
          end else begin
            op_err_q <= 1'b1;
          end
        end
        DONE: begin
          calc_a_q       <= chain_i ? result_q[OPND_W-1:0] : sw_val_i;
          result_valid_q <= 1'b0;
          state_q        <= GET_B;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign calc_a_o       = calc_a_q;
  assign calc_b_o       = calc_b_q;
  assign calc_op_o      = calc_op_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign busy_o         = busy_q;
  assign op_err_o       = op_err_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural calculator alongside it.
module tb_calc_sequencer;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_val = '0;
  logic [2:0] sw_op = '0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic       chain = 1'b0;
  logic [3:0] calc_a, calc_b;
  logic [2:0] calc_op;
  logic [7:0] calc_result;
  logic [7:0] result;
  logic       result_valid, busy, op_err;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_sequencer #(.SETTLE_CYCLES(S), .NUM_OPS(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .sw_val_i       (sw_val),
    .sw_op_i        (sw_op),
    .btn_enter_i    (btn_enter),
    .btn_clear_i    (btn_clear),
    .chain_i        (chain),
    .calc_a_o       (calc_a),
    .calc_b_o       (calc_b),
    .calc_op_o      (calc_op),
    .calc_result_i  (calc_result),
    .result_o       (result),
    .result_valid_o (result_valid),
    .busy_o         (busy),
    .op_err_o       (op_err),
    .state_dbg_o    (state_dbg)
  );

  always_comb begin
    calc_result = 8'd0;
    case (calc_op)
      3'd0: calc_result = {4'd0, calc_a} + {4'd0, calc_b};
      3'd1: calc_result = {4'd0, calc_a} - {4'd0, calc_b};
      3'd2: calc_result = {4'd0, calc_a & calc_b};
      3'd3: calc_result = {4'd0, calc_a | calc_b};
      3'd4: calc_result = {4'd0, calc_a ^ calc_b};
      3'd5: calc_result = calc_a * calc_b;
      default: calc_result = 8'd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_val(input logic [3:0] v);
    sw_val = v; btn_enter = 1'b1;
    tick();
    btn_enter = 1'b0;
  endtask

  task automatic press_op(input logic [2:0] o);
    sw_op = o; btn_enter = 1'b1;
    tick();
    btn_enter = 1'b0;
  endtask

  task automatic pulse_clear();
    btn_clear = 1'b1;
    tick();
    btn_clear = 1'b0;
  endtask

  // Clocks from the opcode ENTER until result_valid, bounded at 20.
  task automatic wait_valid(output int n);
    n = 1;
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    checks++;
    if ({calc_a, calc_b, calc_op, result} !== 19'd0) begin
      errors++; $display("FAIL reset_data got a=%0d b=%0d op=%0d r=%0d exp all 0", calc_a, calc_b, calc_op, result);
    end
    checks++;
    if ({result_valid, busy, op_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {result_valid, busy, op_err});
    end
  endtask

  task automatic test_basic_add();
    int busy_cnt;
    int n;
    press_val(4'd1);
    checks++;
    if (state_dbg !== 3'd1 || calc_a !== 4'd1) begin
      errors++; $display("FAIL add_latch_a got state=%0d a=%0d exp state=1 a=1", state_dbg, calc_a);
    end
    press_val(4'd1);
    press_op(3'd0);
    busy_cnt = busy ? 1 : 0;
    n = 1;
    while (!result_valid && n < 20) begin
      tick();
      n++;
      if (busy) busy_cnt++;
    end
    checks++;
    if (n !== S + 1) begin errors++; $display("FAIL add_latency got %0d exp %0d", n, S + 1); end
    checks++;
    if (busy_cnt !== S) begin errors++; $display("FAIL add_busy_cycles got %0d exp %0d", busy_cnt, S); end
    checks++;
    if (result !== 8'd2 || state_dbg !== 3'd4) begin
      errors++; $display("FAIL add_result got r=%0d state=%0d exp r=2 state=4", result, state_dbg);
    end
  endtask

  task automatic test_chain();
    int n;
    chain = 1'b0;
    press_val(4'd3);
    press_val(4'd4);
    press_op(3'd0);
    wait_valid(n);
    checks++;
    if (result !== 8'd7) begin errors++; $display("FAIL chain_first got %0d exp 7", result); end
    chain = 1'b1;
    press_val(4'd15);
    chain = 1'b0;
    checks++;
    if (calc_a !== 4'd7 || state_dbg !== 3'd1 || result_valid !== 1'b0) begin
      errors++; $display("FAIL chain_a got a=%0d state=%0d v=%0d exp a=7 state=1 v=0", calc_a, state_dbg, result_valid);
    end
    press_val(4'd2);
    press_op(3'd0);
    wait_valid(n);
    checks++;
    if (result !== 8'd9 || n !== S + 1) begin
      errors++; $display("FAIL chain_result got r=%0d lat=%0d exp r=9 lat=%0d", result, n, S + 1);
    end
  endtask

  task automatic test_illegal_op();
    int n;
    pulse_clear();
    checks++;
    if (state_dbg !== 3'd0) begin errors++; $display("FAIL clear_idle got %0d exp 0", state_dbg); end
    press_val(4'd5);
    press_val(4'd3);
    press_op(3'd7);
    checks++;
    if (op_err !== 1'b1 || state_dbg !== 3'd2 || calc_op !== 3'd0) begin
      errors++; $display("FAIL illegal_op got err=%0d state=%0d op=%0d exp err=1 state=2 op=0", op_err, state_dbg, calc_op);
    end
    press_op(3'd1);
    checks++;
    if (op_err !== 1'b0 || state_dbg !== 3'd3) begin
      errors++; $display("FAIL legal_after_err got err=%0d state=%0d exp err=0 state=3", op_err, state_dbg);
    end
    wait_valid(n);
    checks++;
    if (result !== 8'd2 || calc_op !== 3'd1) begin
      errors++; $display("FAIL sub_result got r=%0d op=%0d exp r=2 op=1", result, calc_op);
    end
  endtask

  task automatic test_clear_exec();
    int n;
    press_val(4'd6);
    press_val(4'd2);
    press_op(3'd0);
    btn_clear = 1'b1;
    tick();
    btn_clear = 1'b0;
    n = 2;
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (result_valid !== 1'b1 || result !== 8'd8 || n !== S + 1) begin
      errors++; $display("FAIL clear_exec_capture got v=%0d r=%0d lat=%0d exp v=1 r=8 lat=%0d", result_valid, result, n, S + 1);
    end
    tick();
    checks++;
    if (state_dbg !== 3'd0 || result_valid !== 1'b0 || result !== 8'd8) begin
      errors++; $display("FAIL clear_exec_after got state=%0d v=%0d r=%0d exp state=0 v=0 r=8", state_dbg, result_valid, result);
    end
  endtask

  task automatic test_clear_enter_getb();
    press_val(4'd4);
    sw_val = 4'd9; btn_enter = 1'b1; btn_clear = 1'b1;
    tick();
    btn_enter = 1'b0; btn_clear = 1'b0;
    checks++;
    if (state_dbg !== 3'd0 || calc_b !== 4'd2 || calc_a !== 4'd4) begin
      errors++; $display("FAIL clear_enter got state=%0d a=%0d b=%0d exp state=0 a=4 b=2", state_dbg, calc_a, calc_b);
    end
  endtask

  task automatic test_reset_exec();
    bit seen;
    press_val(4'd1);
    press_val(4'd2);
    press_op(3'd0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_exec_busy got %0d exp 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({calc_a, calc_b, calc_op, result, result_valid, busy, op_err, state_dbg} !== 25'd0) begin
      errors++; $display("FAIL rst_exec_outputs got a=%0d b=%0d op=%0d r=%0d v=%0d busy=%0d err=%0d state=%0d exp all 0",
                         calc_a, calc_b, calc_op, result, result_valid, busy, op_err, state_dbg);
    end
    seen = 1'b0;
    for (int i = 0; i < S + 3; i++) begin
      tick();
      if (result_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || state_dbg !== 3'd0) begin
      errors++; $display("FAIL rst_exec_no_capture got seen=%0d state=%0d exp seen=0 state=0", seen, state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_chain();
    test_illegal_op();
    test_clear_exec();
    test_clear_enter_getb();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
